ip_ascii8_mapper: RTL and testbench
===================================

Name: ip_ascii8_mapper

Overview:
- Slot-side memory device on the internal bus; consumes the synchronised bus strobes (bus_read/bus_write single-cycle pulses, bus_memory qualifier) produced by the MSX bus protocol converter.
- Implements an ASCII-8K MegaROM mapper: four 8 KB windows in 0x4000–0xBFFF, each with a bank register written through 0x6000–0x7FFF.
- Translates accepted reads into a request/valid handshake toward external ROM storage (PSRAM/flash controller).
- Returns bus_read_ready/bus_read_data to the converter, with a timeout fallback.

Parameters:
- BANK_BITS, 8, width of each bank register; ROM size = 2^BANK_BITS × 8 KB.
- TIMEOUT, 63, maximum cycles waited for mem_valid after mem_rd before returning 0xFF; legal range 1..255.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  synchronous, active-low reset.
- bus_address  input  16  latched CPU address.
- bus_memory  input  1  slot selected and this block's memory_cs asserted.
- bus_read  input  1  one-cycle read strobe.
- bus_write  input  1  one-cycle write strobe.
- bus_write_data  input  8  write data, valid with bus_write.
- bus_memory_cs  output  1  combinational decode: 1 when bus_address is in 0x4000..0xBFFF.
- bus_read_ready  output  1  one-cycle pulse; bus_read_data is valid in the same cycle.
- bus_read_data  output  8  read data.
- mem_address  output  BANK_BITS+13  ROM byte address.
- mem_rd  output  1  one-cycle read request.
- mem_valid  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  input  8  ROM data.

Behaviour:
- Reset values:
  - bank0..bank3 = 0.
  - State = ST_IDLE.
  - mem_rd = 0, mem_address = 0.
  - bus_read_ready = 0, bus_read_data = 8'hFF.
  - Timeout counter = 0.
- Window index = {bus_address[15], bus_address[13]}. Mapping: 0x4000→0, 0x6000→1, 0x8000→2, 0xA000→3.
- Bank write:
  - Condition: bus_write & bus_memory & bus_address[15:13] == 3'b011.
  - Target: bank[bus_address[12:11]] <= bus_write_data[BANK_BITS-1:0]; upper data bits are dropped.
  - Takes effect the next cycle.
  - All other writes are ignored; the block has no RAM.
- Read accept:
  - Condition: bus_read & bus_memory & bus_memory_cs in ST_IDLE.
  - Next cycle: mem_address = {bank[idx], bus_address[12:0]}, registered at accept; mem_rd = 1 for exactly one cycle; state goes ST_IDLE → ST_WAIT.
- ST_WAIT:
  - Counter increments each cycle.
  - On mem_valid: bus_read_data <= mem_rdata; bus_read_ready pulses the following cycle; state returns to ST_IDLE.
  - When the counter reaches TIMEOUT without mem_valid: bus_read_data <= 8'hFF; bus_read_ready pulses; state returns to ST_IDLE.
  - If mem_valid and the timeout fall in the same cycle, mem_valid wins.
- Latency: bus_read at cycle t → mem_rd at t+1 → mem_valid at t+1+k (k ≥ 0) → bus_read_ready at t+2+k.
- bus_read_data holds its value between reads.
- Boundary conditions:
  - bus_read while in ST_WAIT is dropped; no queueing and no second mem_rd.
  - A bank write during ST_WAIT is applied, but the in-flight mem_address is unaffected.
  - A bank write and a read accept in the same cycle: the read uses the old bank value.
  - mem_valid outside ST_WAIT is ignored.
  - bus_read with bus_memory = 0 or an address outside the window: no request is issued and no ready pulse is produced.
  - bus_io traffic is not an input; I/O cycles are never decoded.
  - Reset asserted mid-ST_WAIT: all state is cleared. A later mem_valid is ignored and no bus_read_ready pulse is emitted.

Test Plan:
- Reset, then read 0x4123 with mem_valid k=2 and rdata 0x5A → mem_address 0x00123; mem_rd at t+1; bus_read_ready at t+4 with data 0x5A.
- Write 0x07 to 0x7000, then read 0x8001 → mem_address = 0x0E001 (bank 7 × 0x2000 + 1); write to 0x7800 = 0xFF, then read 0xBFFF → mem_address 0x1FFFFF.
- Read with mem_valid never asserted, TIMEOUT=63 → bus_read_ready exactly 63 cycles after mem_rd, data 0xFF, state back to ST_IDLE.
- Second bus_read during ST_WAIT plus a write 0x03 to 0x6800 in the same window → only one mem_rd and one ready pulse; next read of 0x6000 uses bank 3 (address 0x06000).
- Read 0x3FFF, read 0xC000, write 0x5000, and a read with bus_memory=0 → bus_memory_cs=0 for the out-of-window addresses, no mem_rd, banks unchanged.
- n_reset pulsed in ST_WAIT, then mem_valid → no bus_read_ready; banks read back as 0 (read 0xA000 → mem_address 0x00000).

Source files
------------

// File: rtl/ip_ascii8_mapper.sv
// ASCII-8K MegaROM mapper: four 8 KB windows in 0x4000-0xBFFF, bank registers at 0x6000-0x7FFF,
// reads forwarded to external ROM storage through a request/valid handshake with a timeout fallback.
module ip_ascii8_mapper #(
  parameter int unsigned BANK_BITS = 8,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [15:0]            bus_address,
  input  logic                   bus_memory,
  input  logic                   bus_read,
  input  logic                   bus_write,
  input  logic [7:0]             bus_write_data,
  output logic                   bus_memory_cs,
  output logic                   bus_read_ready,
  output logic [7:0]             bus_read_data,
  output logic [BANK_BITS+12:0]  mem_address,
  output logic                   mem_rd,
  input  logic                   mem_valid,
  input  logic [7:0]             mem_rdata
);

  localparam int unsigned OFFS_W = 13;
  localparam int unsigned ADDR_W = BANK_BITS + OFFS_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NBANKS = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BANK_BITS-1:0] bank_q [NBANKS];
  logic [BANK_BITS-1:0] bank_d [NBANKS];
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 ready_q, ready_d;
  logic [7:0]           rdata_q, rdata_d;

  logic                 bank_wr;
  logic                 rd_accept;
  logic [1:0]           win_idx;
  logic [1:0]           bank_sel;

  // Window decode is purely combinational so the converter can route the cycle immediately.
  assign bus_memory_cs = bus_address[15] ^ bus_address[14];

  assign win_idx   = {bus_address[15], bus_address[13]};
  assign bank_sel  = bus_address[12:11];
  assign bank_wr   = bus_write & bus_memory & (bus_address[15:13] == 3'b011);
  assign rd_accept = bus_read & bus_memory & bus_memory_cs;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 8'hFF;
      for (int i = 0; i < int'(NBANKS); i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < int'(NBANKS); i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Next-state logic; bank_q (not bank_d) feeds the address so a same-cycle bank write is not seen.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    for (int i = 0; i < int'(NBANKS); i++) begin
      bank_d[i] = bank_q[i];
    end

    if (bank_wr) begin
      bank_d[bank_sel] = bus_write_data[BANK_BITS-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_accept) begin
          state_d    = ST_WAIT;
          mem_rd_d   = 1'b1;
          mem_addr_d = {bank_q[win_idx], bus_address[OFFS_W-1:0]};
          cnt_d      = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // Late data still wins over the timeout when both land in the same cycle.
        if (mem_valid) begin
          state_d = ST_IDLE;
          rdata_d = mem_rdata;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = ST_IDLE;
          rdata_d = 8'hFF;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_address    = mem_addr_q;
  assign mem_rd         = mem_rd_q;
  assign bus_read_ready = ready_q;
  assign bus_read_data  = rdata_q;

endmodule

// File: tb/tb_ip_ascii8_mapper.sv
// Scoreboard bench for ip_ascii8_mapper: stimulus pushes expected mem_rd / ready events, a monitor checks them.
module tb_ip_ascii8_mapper;

  localparam int unsigned BANK_BITS = 8;
  localparam int unsigned TIMEOUT   = 63;
  localparam int unsigned ADDR_W    = BANK_BITS + 13;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [15:0]       bus_address;
  logic              bus_memory;
  logic              bus_read;
  logic              bus_write;
  logic [7:0]        bus_write_data;
  logic              bus_memory_cs;
  logic              bus_read_ready;
  logic [7:0]        bus_read_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rd;
  logic              mem_valid;
  logic [7:0]        mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] val;
    int                cyc;
  } exp_t;

  exp_t mem_q[$];
  exp_t rd_q[$];

  ip_ascii8_mapper #(.BANK_BITS(BANK_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .bus_address    (bus_address),
    .bus_memory     (bus_memory),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_write_data (bus_write_data),
    .bus_memory_cs  (bus_memory_cs),
    .bus_read_ready (bus_read_ready),
    .bus_read_data  (bus_read_data),
    .mem_address    (mem_address),
    .mem_rd         (mem_rd),
    .mem_valid      (mem_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mem_rd and bus_read_ready pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rd === 1'b1) begin
      if (mem_q.size() == 0) begin
        check("unexpected_mem_rd", 32'(mem_address), 32'hDEAD);
      end else begin
        e = mem_q.pop_front();
        check("mem_address", 32'(mem_address), 32'(e.val));
        check("mem_rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bus_read_ready === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("unexpected_ready", 32'(bus_read_data), 32'hDEAD);
      end else begin
        e = rd_q.pop_front();
        check("read_data", 32'(bus_read_data), 32'(e.val));
        check("ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic mem);
    @(posedge clk); #1;
    bus_address = addr; bus_memory = mem; bus_write = 1'b1; bus_write_data = data;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_memory = 1'b0;
  endtask

  // k < 0: mem_valid is never driven and the timeout response is expected.
  task automatic do_read(input logic [15:0] addr, input logic [ADDR_W-1:0] exp_addr, input int k,
                         input logic [7:0] data, input logic wr, input logic [7:0] wdata);
    int t;
    exp_t e;
    @(posedge clk); #1;
    bus_address = addr; bus_memory = 1'b1; bus_read = 1'b1;
    bus_write = wr; bus_write_data = wdata;
    t = cyc;
    e.val = exp_addr; e.cyc = t + 1; mem_q.push_back(e);
    if (k < 0) begin
      e.val = ADDR_W'(8'hFF); e.cyc = t + 1 + int'(TIMEOUT);
    end else begin
      e.val = ADDR_W'(data); e.cyc = t + 2 + k;
    end
    rd_q.push_back(e);
    @(posedge clk); #1;
    bus_read = 1'b0; bus_write = 1'b0; bus_memory = 1'b0;
    if (k < 0) begin
      idle(int'(TIMEOUT) + 3);
    end else begin
      idle(k);
      mem_valid = 1'b1; mem_rdata = data;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      idle(3);
    end
  endtask

  task automatic do_noreq(input logic [15:0] addr, input logic mem, input logic exp_cs);
    @(posedge clk); #1;
    bus_address = addr; bus_memory = mem; bus_read = 1'b1;
    #1 check("memory_cs", 32'(bus_memory_cs), 32'(exp_cs));
    @(posedge clk); #1;
    bus_read = 1'b0; bus_memory = 1'b0;
    idle(4);
  endtask

  initial begin
    int t;
    exp_t e;
    n_reset = 1'b0; bus_address = '0; bus_memory = 1'b0; bus_read = 1'b0;
    bus_write = 1'b0; bus_write_data = '0; mem_valid = 1'b0; mem_rdata = '0;
    idle(3);
    check("rst_ready", 32'(bus_read_ready), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_read_data", 32'(bus_read_data), 32'hFF);
    n_reset = 1'b1;
    idle(2);

    // Basic read with k=2.
    do_read(16'h4123, 21'h00123, 2, 8'h5A, 1'b0, 8'h00);
    // Bank writes then reads through windows 2 and 3.
    do_write(16'h7000, 8'h07, 1'b1);
    do_read(16'h8001, 21'h0E001, 0, 8'h11, 1'b0, 8'h00);
    do_write(16'h7800, 8'hFF, 1'b1);
    do_read(16'hBFFF, 21'h1FFFFF, 1, 8'h22, 1'b0, 8'h00);
    idle(5);
    check("data_hold", 32'(bus_read_data), 32'h22);

    // Timeout with no mem_valid.
    do_read(16'h4000, 21'h00000, -1, 8'h00, 1'b0, 8'h00);

    // Dropped read and bank write while a read is in flight.
    @(posedge clk); #1;
    bus_address = 16'hA010; bus_memory = 1'b1; bus_read = 1'b1;
    t = cyc;
    e.val = 21'h1FE010; e.cyc = t + 1; mem_q.push_back(e);
    e.val = 21'h33;     e.cyc = t + 6; rd_q.push_back(e);
    @(posedge clk); #1; bus_read = 1'b0;
    @(posedge clk); #1; bus_address = 16'h4000; bus_read = 1'b1;
    @(posedge clk); #1; bus_read = 1'b0; bus_address = 16'h6800; bus_write = 1'b1; bus_write_data = 8'h03;
    @(posedge clk); #1; bus_write = 1'b0; bus_memory = 1'b0;
    @(posedge clk); #1; mem_valid = 1'b1; mem_rdata = 8'h33;
    @(posedge clk); #1; mem_valid = 1'b0;
    idle(3);
    // Stray mem_valid while idle.
    mem_valid = 1'b1; mem_rdata = 8'h99;
    @(posedge clk); #1; mem_valid = 1'b0;
    idle(3);
    check("stray_valid_hold", 32'(bus_read_data), 32'h33);
    do_read(16'h6000, 21'h06000, 0, 8'h44, 1'b0, 8'h00);

    // Bank write and read accept in the same cycle: read sees old bank1.
    do_read(16'h6800, 21'h06800, 1, 8'h55, 1'b1, 8'h09);
    do_read(16'h6800, 21'h12800, 0, 8'h66, 1'b0, 8'h00);

    // Out-of-window and unselected accesses.
    do_noreq(16'h3FFF, 1'b1, 1'b0);
    do_noreq(16'hC000, 1'b1, 1'b0);
    do_noreq(16'h4000, 1'b0, 1'b1);
    do_write(16'h5000, 8'h55, 1'b1);
    do_write(16'h6000, 8'h12, 1'b0);
    do_read(16'h4000, 21'h00000, 0, 8'h77, 1'b0, 8'h00);
    do_read(16'h8000, 21'h0E000, 0, 8'h78, 1'b0, 8'h00);

    // Reset in the middle of a wait.
    @(posedge clk); #1;
    bus_address = 16'hA000; bus_memory = 1'b1; bus_read = 1'b1;
    t = cyc;
    e.val = 21'h1FE000; e.cyc = t + 1; mem_q.push_back(e);
    @(posedge clk); #1; bus_read = 1'b0; bus_memory = 1'b0;
    @(posedge clk); #1; n_reset = 1'b0;
    @(posedge clk); #1; n_reset = 1'b1;
    check("rst_mid_data", 32'(bus_read_data), 32'hFF);
    mem_valid = 1'b1; mem_rdata = 8'hAB;
    @(posedge clk); #1; mem_valid = 1'b0;
    idle(4);
    do_read(16'hA000, 21'h00000, 0, 8'hCD, 1'b0, 8'h00);

    idle(5);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
